// File: rtl/iir_pkg.sv
// Shared definitions for the IIR sample sequencer: default sample width,
// sequencer state encoding and a saturating counter helper.
package iir_pkg;

  localparam int IIR_SIGNAL_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_COLLECT = 2'd3
  } seq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small first-word-fall-through FIFO for ADC samples. When full, a push is
// accepted only if a pop happens in the same cycle.
module sample_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/iir_sample_sequencer.sv
// Feeds buffered ADC samples one at a time to an external IIR filter and
// returns its results in order, with overflow and hung-filter detection.
module iir_sample_sequencer
  import iir_pkg::*;
#(
  parameter int SIGNAL_BITS    = IIR_SIGNAL_BITS,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          sample_valid_i,
  input  logic signed [SIGNAL_BITS-1:0] sample_i,
  output logic                          filt_start_o,
  output logic signed [SIGNAL_BITS-1:0] filt_signal_o,
  input  logic signed [SIGNAL_BITS-1:0] filt_signal_i,
  input  logic                          filt_done_i,
  output logic                          result_valid_o,
  output logic signed [SIGNAL_BITS-1:0] result_o,
  input  logic                          clear_flags_i,
  output logic                          overflow_o,
  output logic [15:0]                   drop_count_o,
  output logic                          timeout_o
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  seq_state_t             state_r, next_state_s;
  logic [TIMER_W-1:0]     timer_r;
  logic                   filt_start_r, result_valid_r, overflow_r, timeout_r;
  logic [SIGNAL_BITS-1:0] filt_signal_r, result_r, fifo_head_s;
  logic [15:0]            drop_count_r;
  logic                   fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
  logic                   bypass_s, load_s, capture_s, timeout_hit_s, drop_s;

  sample_fifo #(
    .DATA_W (SIGNAL_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .wr_data (sample_i),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // An idle sequencer takes an arriving sample straight to the filter so the
  // start pulse follows the sample by one cycle; otherwise the head is popped.
  assign fifo_push_s = sample_valid_i && !bypass_s;
  assign drop_s      = fifo_push_s && fifo_full_s && !fifo_pop_s;

  // Next-state and control decode.
  always_comb begin
    next_state_s  = state_r;
    fifo_pop_s    = 1'b0;
    bypass_s      = 1'b0;
    load_s        = 1'b0;
    capture_s     = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s   = 1'b1;
          load_s       = 1'b1;
          next_state_s = ST_ISSUE;
        end else if (sample_valid_i) begin
          bypass_s     = 1'b1;
          load_s       = 1'b1;
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE:   next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (filt_done_i) begin
          capture_s    = 1'b1;
          next_state_s = ST_COLLECT;
        end else if (timer_r == TIMER_LAST) begin
          timeout_hit_s = 1'b1;
          next_state_s  = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_COLLECT: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // State, WAIT timer and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r        <= ST_IDLE;
      timer_r        <= '0;
      filt_start_r   <= 1'b0;
      filt_signal_r  <= '0;
      result_valid_r <= 1'b0;
      result_r       <= '0;
    end else begin
      state_r        <= next_state_s;
      timer_r        <= (state_r == ST_WAIT) ? timer_r + TIMER_W'(1) : '0;
      filt_start_r   <= load_s;
      result_valid_r <= capture_s;
      if (load_s) begin
        filt_signal_r <= bypass_s ? sample_i : fifo_head_s;
      end
      if (capture_s) begin
        result_r <= filt_signal_i;
      end
    end
  end

  // Sticky flags and drop counter; clear wins over a same-cycle event.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_r   <= 1'b0;
      timeout_r    <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (clear_flags_i) begin
      overflow_r   <= 1'b0;
      timeout_r    <= 1'b0;
      drop_count_r <= 16'd0;
    end else begin
      if (drop_s) begin
        overflow_r   <= 1'b1;
        drop_count_r <= sat_inc16(drop_count_r);
      end
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign filt_start_o   = filt_start_r;
  assign filt_signal_o  = filt_signal_r;
  assign result_valid_o = result_valid_r;
  assign result_o       = result_r;
  assign overflow_o     = overflow_r;
  assign drop_count_o   = drop_count_r;
  assign timeout_o      = timeout_r;

endmodule

// File: tb/tb_iir_sample_sequencer.sv
// Directed bench for iir_sample_sequencer with a behavioural filter model
// whose output is its input minus 500, answering a set number of cycles after start.
module tb_iir_sample_sequencer;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               sample_valid_i;
  logic signed [23:0] sample_i;
  logic               filt_start_o;
  logic signed [23:0] filt_signal_o;
  logic signed [23:0] filt_signal_i;
  logic               filt_done_i;
  logic               result_valid_o;
  logic signed [23:0] result_o;
  logic               clear_flags_i;
  logic               overflow_o;
  logic [15:0]        drop_count_o;
  logic               timeout_o;

  int checks = 0;
  int errors = 0;

  int                 model_lat = 5;
  logic               model_en = 1'b1;
  int                 model_cnt = 0;
  logic signed [23:0] model_sig = '0;
  logic signed [23:0] model_out = '0;
  logic               model_done = 1'b0;
  logic               manual_done = 1'b0;

  assign filt_done_i   = model_done | manual_done;
  assign filt_signal_i = model_out;

  always #5 clk_i = ~clk_i;

  iir_sample_sequencer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .filt_start_o   (filt_start_o),
    .filt_signal_o  (filt_signal_o),
    .filt_signal_i  (filt_signal_i),
    .filt_done_i    (filt_done_i),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .clear_flags_i  (clear_flags_i),
    .overflow_o     (overflow_o),
    .drop_count_o   (drop_count_o),
    .timeout_o      (timeout_o)
  );

  // Filter model: done is high during the cycle model_lat cycles after start.
  always @(negedge clk_i) begin
    model_done = 1'b0;
    if (filt_start_o) begin
      model_cnt = model_lat;
      model_sig = filt_signal_o;
    end else if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0 && model_en) begin
        model_done = 1'b1;
        model_out  = model_sig - 24'sd500;
      end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, filt_start_o, 0);
    chk({tag, "_signal"}, filt_signal_o, 0);
    chk({tag, "_rvalid"}, result_valid_o, 0);
    chk({tag, "_result"}, result_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_drops"}, drop_count_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
  endtask

  task automatic burst_and_collect(input logic clear_at_drop, output int n_res,
                                   output int res0, output int res4);
    n_res = 0;
    res0  = 99999;
    res4  = 99999;
    for (int i = 0; i < 60; i++) begin
      if (result_valid_o) begin
        if (n_res == 0) res0 = result_o;
        if (n_res == 4) res4 = result_o;
        if (n_res < 5) chk("burst_order", result_o, n_res + 1 - 500);
        n_res++;
      end
      sample_valid_i = (i < 6);
      sample_i       = 24'(i + 1);
      clear_flags_i  = clear_at_drop && (i == 5);
      step();
    end
    sample_valid_i = 1'b0;
    clear_flags_i  = 1'b0;
  endtask

  int lat_seen, n_res, res0, res4, to_cyc, res_cyc, res_val, stray;

  initial begin
    reset_i        = 1'b1;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    clear_flags_i  = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset_i = 1'b0;
    step();

    // Single sample, done 5 cycles after start.
    model_lat      = 5;
    sample_valid_i = 1'b1;
    sample_i       = 24'sd1000;
    step();
    sample_valid_i = 1'b0;
    chk("single_start", filt_start_o, 1);
    chk("single_signal", filt_signal_o, 1000);
    lat_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) chk("single_start_pulse", filt_start_o, 0);
      if (result_valid_o) begin
        lat_seen = i;
        break;
      end
    end
    chk("single_latency", lat_seen, 6);
    chk("single_result", result_o, 500);
    step();
    chk("single_rvalid_one", result_valid_o, 0);
    chk("single_signal_hold", filt_signal_o, 1000);

    // Spurious done while idle.
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    chk("spurious_rvalid", result_valid_o, 0);
    chk("spurious_start", filt_start_o, 0);
    step();
    chk("spurious_rvalid2", result_valid_o, 0);
    chk("spurious_result", result_o, 500);

    // Burst of six into a four-deep FIFO.
    model_lat = 3;
    burst_and_collect(1'b0, n_res, res0, res4);
    chk("burst_count", n_res, 5);
    chk("burst_first", res0, -499);
    chk("burst_last", res4, -495);
    chk("burst_ovf", overflow_o, 1);
    chk("burst_drops", drop_count_o, 1);

    clear_flags_i = 1'b1;
    step();
    clear_flags_i = 1'b0;
    chk("clear_ovf", overflow_o, 0);
    chk("clear_drops", drop_count_o, 0);

    // Drop in the same cycle as clear.
    burst_and_collect(1'b1, n_res, res0, res4);
    chk("clrdrop_count", n_res, 5);
    chk("clrdrop_ovf", overflow_o, 0);
    chk("clrdrop_drops", drop_count_o, 0);

    // Hung filter, then the buffered sample is served normally.
    model_lat = 2;
    model_en  = 1'b0;
    to_cyc    = -1;
    res_cyc   = -1;
    res_val   = 99999;
    for (int i = 0; i < 200; i++) begin
      if (timeout_o && to_cyc < 0) begin
        to_cyc   = i;
        model_en = 1'b1;
      end
      if (result_valid_o) begin
        res_cyc = i;
        res_val = result_o;
        break;
      end
      sample_valid_i = (i < 2);
      sample_i       = (i == 0) ? 24'sd10 : 24'sd20;
      step();
    end
    sample_valid_i = 1'b0;
    chk("timeout_cycle", to_cyc, 66);
    chk("timeout_next_result_cycle", res_cyc, 70);
    chk("timeout_next_result", res_val, -480);
    chk("timeout_sticky", timeout_o, 1);
    clear_flags_i = 1'b1;
    step();
    clear_flags_i = 1'b0;
    chk("timeout_clear", timeout_o, 0);
    step();

    // Reset two cycles into WAIT, late done afterwards.
    model_lat      = 5;
    sample_valid_i = 1'b1;
    sample_i       = 24'sd77;
    step();
    sample_valid_i = 1'b0;
    step();
    step();
    reset_i = 1'b1;
    step();
    check_all_zero("midwait_reset");
    reset_i = 1'b0;
    stray   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (result_valid_o || filt_start_o) stray++;
    end
    chk("late_done_ignored", stray, 0);
    check_all_zero("after_reset");

    // Sequencer is back in IDLE: a new sample starts the filter next cycle.
    sample_valid_i = 1'b1;
    sample_i       = 24'sd123;
    step();
    sample_valid_i = 1'b0;
    chk("post_reset_start", filt_start_o, 1);
    chk("post_reset_signal", filt_signal_o, 123);
    res_val = 99999;
    for (int i = 0; i < 20; i++) begin
      step();
      if (result_valid_o) begin
        res_val = result_o;
        break;
      end
    end
    chk("post_reset_result", res_val, -377);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_sample_sequencer.md
IIR_SAMPLE_SEQUENCER -- requirements
Module: iir_sample_sequencer

Interface
REQ-001 Parameter SIGNAL_BITS, default 24, is the width of every sample and result.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2), is the number of input samples buffered.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, is the maximum number of WAIT cycles before the filter is declared hung.
REQ-004 Port clk_i, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset_i, input, 1: asynchronous, active-high reset.
REQ-006 Port sample_valid_i, input, 1: sample_i is presented this cycle (ADC stream, no backpressure).
REQ-007 Port sample_i, input, SIGNAL_BITS, signed: input sample.
REQ-008 Port filt_start_o, output, 1: one-cycle start pulse to the filter's start_i.
REQ-009 Port filt_signal_o, output, SIGNAL_BITS, signed: sample to the filter's signal_i.
REQ-010 Port filt_signal_i, input, SIGNAL_BITS, signed: the filter's signal_o.
REQ-011 Port filt_done_i, input, 1: the filter's done_o.
REQ-012 Port result_valid_o, output, 1: result_o is valid for this cycle only.
REQ-013 Port result_o, output, SIGNAL_BITS, signed: captured filter output.
REQ-014 Port clear_flags_i, input, 1: clears the sticky flags and the drop counter.
REQ-015 Port overflow_o, output, 1: sticky flag set when a sample is dropped.
REQ-016 Port drop_count_o, output, 16: saturating count of dropped samples.
REQ-017 Port timeout_o, output, 1: sticky flag set when the filter fails to answer.

Function
REQ-018 Samples with sample_valid_i=1 SHALL be pushed into a FIFO_DEPTH-entry FIFO.
REQ-019 A push when the FIFO is full and no pop occurs SHALL drop the sample, set overflow_o and increment drop_count_o, saturating at 0xFFFF.
REQ-020 A push and a pop in the same cycle while full SHALL accept the push and drop nothing.
REQ-021 FSM states: IDLE, ISSUE, WAIT, COLLECT.
REQ-022 IDLE SHALL go to ISSUE when the FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-023 ISSUE SHALL last exactly one cycle, assert filt_start_o, pop the FIFO head into the filt_signal_o register, and go to WAIT.
REQ-024 filt_signal_o SHALL hold stable from ISSUE until the next ISSUE.
REQ-025 In WAIT, filt_done_i=1 SHALL capture filt_signal_i into result_o and go to COLLECT.
REQ-026 COLLECT SHALL assert result_valid_o for exactly one cycle and then return to IDLE.
REQ-027 A timeout counter SHALL clear on entry to WAIT; if TIMEOUT_CYCLES cycles pass without filt_done_i, the FSM SHALL set timeout_o and return to IDLE with no result_valid_o.
REQ-028 filt_done_i outside WAIT SHALL be ignored.
REQ-029 Latency:
- A sample pushed at cycle N into an empty FIFO in IDLE SHALL give filt_start_o=1 at cycle N+1.
- filt_done_i sampled high at cycle M SHALL give result_valid_o=1 at cycle M+1.
REQ-030 clear_flags_i SHALL clear overflow_o, timeout_o and drop_count_o on the next edge, with priority over a same-cycle set or increment.
REQ-031 Results SHALL leave in the same order as their samples arrived, one result per issued sample unless a timeout occurs.

Reset
REQ-032 reset_i SHALL asynchronously force the FSM to IDLE and empty the FIFO.
REQ-033 reset_i SHALL drive filt_start_o, result_valid_o, overflow_o and timeout_o to 0, and filt_signal_o, result_o and drop_count_o to 0.
REQ-034 Reset asserted mid-WAIT SHALL abandon the outstanding sample; a filt_done_i arriving after reset releases SHALL be ignored.

Structure
REQ-035 SIGNAL_BITS default and the state enum type SHALL live in shared package iir_pkg.
REQ-036 The FIFO SHALL be a sub-module named sample_fifo, with push/pop/full/empty ports and the same clock and reset.

Verification
REQ-037 Single sample 1000 with a filter model giving done 5 cycles after start and output 500 -> filt_start_o 1 cycle later, filt_signal_o=1000, result_o=500 with result_valid_o for one cycle.
REQ-038 Burst of 6 samples (1..6) on consecutive cycles, FIFO_DEPTH=4, done latency 3 -> 1 issued plus 4 buffered, 1 dropped; overflow_o=1, drop_count_o=1; results are in order.
REQ-039 Filter model never asserts done -> timeout_o=1 after 64 WAIT cycles; the next buffered sample is then issued normally.
REQ-040 Reset asserted 2 cycles into WAIT, then a late done pulse -> no result_valid_o, all outputs 0, FSM in IDLE.
REQ-041 Overflow at the same cycle as clear_flags_i -> overflow_o=0 and drop_count_o=0 afterwards.
REQ-042 Spurious filt_done_i in IDLE -> no result_valid_o and no state change.
